// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rsa_pkg
// Desc     : Shared types and constants for the RSA Avalon front-end.
// Revision : 1.0
// ============================================================================
package rsa_pkg;

    localparam logic [4:0] c_ADDR_RX     = 5'd0;
    localparam logic [4:0] c_ADDR_TX     = 5'd4;
    localparam logic [4:0] c_ADDR_STATUS = 5'd8;

    localparam int c_RX_OK_BIT = 7;
    localparam int c_TX_OK_BIT = 6;
    localparam int c_IN_BYTES  = 32;
    localparam int c_OUT_BYTES = 31;

    localparam logic c_DIR_RX = 1'b0;
    localparam logic c_DIR_TX = 1'b1;

    typedef enum logic [2:0] {
        S_GET_N     = 3'd0,
        S_GET_D     = 3'd1,
        S_GET_A     = 3'd2,
        S_START     = 3'd3,
        S_WAIT_CALC = 3'd4,
        S_SEND      = 3'd5
    } rsa_state_t;

    typedef enum logic [2:0] {
        P_IDLE   = 3'd0,
        P_POLL   = 3'd1,
        P_GAP    = 3'd2,
        P_ACCESS = 3'd3,
        P_DONE   = 3'd4
    } port_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_byte_port.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_port
// Desc     : Moves one byte to/from the UART: status poll, then data access.
// Revision : 1.0
// ============================================================================
module uart_byte_port
    import rsa_pkg::*;
#(
    parameter logic [4:0] ADDR_RX     = c_ADDR_RX,
    parameter logic [4:0] ADDR_TX     = c_ADDR_TX,
    parameter logic [4:0] ADDR_STATUS = c_ADDR_STATUS,
    parameter int         RX_OK_BIT   = c_RX_OK_BIT,
    parameter int         TX_OK_BIT   = c_TX_OK_BIT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_dir,
    input  logic [7:0]  i_byte_in,
    output logic        o_done,
    output logic [7:0]  o_byte_out,
    output logic [4:0]  o_avm_address,
    output logic        o_avm_read,
    input  logic [31:0] i_avm_readdata,
    output logic        o_avm_write,
    output logic [31:0] o_avm_writedata,
    input  logic        i_avm_waitrequest
);

    port_state_t r_state;
    port_state_t w_next;
    logic        r_ok;
    logic [7:0]  r_byte;
    logic        w_status_bit;
    logic        w_unused_rdata;

    assign w_status_bit   = (i_dir == c_DIR_TX) ? i_avm_readdata[TX_OK_BIT]
                                                : i_avm_readdata[RX_OK_BIT];
    assign w_unused_rdata = ^i_avm_readdata[31:8];
    assign o_byte_out     = r_byte;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= P_IDLE;
            r_ok    <= 1'b0;
            r_byte  <= 8'h00;
        end else begin
            r_state <= w_next;
            if (r_state == P_POLL && !i_avm_waitrequest) begin
                r_ok <= w_status_bit;
            end
            if (r_state == P_ACCESS && !i_avm_waitrequest && i_dir == c_DIR_RX) begin
                r_byte <= i_avm_readdata[7:0];
            end
        end
    end

    // P_GAP is the mandatory idle cycle after every poll, whatever its outcome.
    always_comb begin
        w_next = r_state;
        case (r_state)
            P_IDLE:   if (i_req) w_next = P_POLL;
            P_POLL:   if (!i_avm_waitrequest) w_next = P_GAP;
            P_GAP:    w_next = r_ok ? P_ACCESS : P_POLL;
            P_ACCESS: if (!i_avm_waitrequest) w_next = P_DONE;
            P_DONE:   w_next = P_IDLE;
            default:  w_next = P_IDLE;
        endcase
    end

    always_comb begin
        o_avm_address   = ADDR_STATUS;
        o_avm_read      = 1'b0;
        o_avm_write     = 1'b0;
        o_avm_writedata = 32'h0000_0000;
        o_done          = 1'b0;
        case (r_state)
            P_POLL: begin
                o_avm_read = 1'b1;
            end
            P_ACCESS: begin
                if (i_dir == c_DIR_TX) begin
                    o_avm_address   = ADDR_TX;
                    o_avm_write     = 1'b1;
                    o_avm_writedata = {24'h00_0000, i_byte_in};
                end else begin
                    o_avm_address = ADDR_RX;
                    o_avm_read    = 1'b1;
                end
            end
            P_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_done = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rsa_avalon_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : rsa_avalon_wrapper
// Desc     : Loads n, d and cipher blocks from the UART, runs the RSA core,
//            and returns each 31-byte result over the UART.
// Revision : 1.0
// ============================================================================
module rsa_avalon_wrapper
    import rsa_pkg::*;
#(
    parameter logic [4:0] ADDR_RX     = c_ADDR_RX,
    parameter logic [4:0] ADDR_TX     = c_ADDR_TX,
    parameter logic [4:0] ADDR_STATUS = c_ADDR_STATUS,
    parameter int         RX_OK_BIT   = c_RX_OK_BIT,
    parameter int         TX_OK_BIT   = c_TX_OK_BIT,
    parameter int         IN_BYTES    = c_IN_BYTES,
    parameter int         OUT_BYTES   = c_OUT_BYTES
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         core_start,
    output logic [255:0] core_a,
    output logic [255:0] core_d,
    output logic [255:0] core_n,
    input  logic [255:0] core_result,
    input  logic         core_finished
);

    localparam int         c_TX_W     = OUT_BYTES * 8;
    localparam logic [4:0] c_IN_LAST  = 5'(IN_BYTES - 1);
    localparam logic [4:0] c_OUT_LAST = 5'(OUT_BYTES - 1);

    rsa_state_t        r_state;
    rsa_state_t        w_next;
    logic [255:0]      r_n;
    logic [255:0]      r_d;
    logic [255:0]      r_a;
    logic [c_TX_W-1:0] r_tx;
    logic [4:0]        r_cnt;

    logic              w_req;
    logic              w_dir;
    logic              w_done;
    logic [7:0]        w_rx_byte;
    logic              w_word_end;
    logic              w_unused_result;

    assign w_word_end      = (r_state == S_SEND) ? (r_cnt == c_OUT_LAST)
                                                 : (r_cnt == c_IN_LAST);
    assign w_unused_result = ^core_result[255:c_TX_W];

    assign core_n = r_n;
    assign core_d = r_d;
    assign core_a = r_a;

    uart_byte_port #(
        .ADDR_RX     (ADDR_RX),
        .ADDR_TX     (ADDR_TX),
        .ADDR_STATUS (ADDR_STATUS),
        .RX_OK_BIT   (RX_OK_BIT),
        .TX_OK_BIT   (TX_OK_BIT)
    ) u_port (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_req             (w_req),
        .i_dir             (w_dir),
        .i_byte_in         (r_tx[c_TX_W-1 -: 8]),
        .o_done            (w_done),
        .o_byte_out        (w_rx_byte),
        .o_avm_address     (avm_address),
        .o_avm_read        (avm_read),
        .i_avm_readdata    (avm_readdata),
        .o_avm_write       (avm_write),
        .o_avm_writedata   (avm_writedata),
        .i_avm_waitrequest (avm_waitrequest)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_GET_N;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_GET_N:     if (w_done && w_word_end) w_next = S_GET_D;
            S_GET_D:     if (w_done && w_word_end) w_next = S_GET_A;
            S_GET_A:     if (w_done && w_word_end) w_next = S_START;
            S_START:     w_next = S_WAIT_CALC;
            S_WAIT_CALC: if (core_finished) w_next = S_SEND;
            S_SEND:      if (w_done && w_word_end) w_next = S_GET_A;
            default:     w_next = S_GET_N;
        endcase
    end

    always_comb begin
        w_req      = 1'b0;
        w_dir      = c_DIR_RX;
        core_start = 1'b0;
        case (r_state)
            S_GET_N, S_GET_D, S_GET_A: w_req = 1'b1;
            S_START:                   core_start = 1'b1;
            S_SEND: begin
                w_req = 1'b1;
                w_dir = c_DIR_TX;
            end
            default: w_req = 1'b0;
        endcase
    end

    // Words arrive MSB first, so each byte enters at the bottom and shifts up.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_n   <= '0;
            r_d   <= '0;
            r_a   <= '0;
            r_tx  <= '0;
            r_cnt <= 5'd0;
        end else begin
            if (w_done) begin
                r_cnt <= w_word_end ? 5'd0 : r_cnt + 5'd1;
            end
            case (r_state)
                S_GET_N: if (w_done) r_n <= {r_n[247:0], w_rx_byte};
                S_GET_D: if (w_done) r_d <= {r_d[247:0], w_rx_byte};
                S_GET_A: if (w_done) r_a <= {r_a[247:0], w_rx_byte};
                S_WAIT_CALC: if (core_finished) r_tx <= core_result[c_TX_W-1:0];
                S_SEND:  if (w_done) r_tx <= {r_tx[c_TX_W-9:0], 8'h00};
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/rsa_avalon_wrapper.md
Name: rsa_avalon_wrapper

Overview:
- Front-end controller that drives the RSA-256 exponentiation core through its start/finished interface.
- Acts as an Avalon-MM master to the RS-232 UART core. Receives modulus n, then exponent d, then a stream of 256-bit cipher blocks. Starts the core once per block and transmits the 31-byte result back over the UART.
- Sits between the UART IP and the RSA core in the top-level design.

Parameters:
- ADDR_RX, 0, UART rxdata register address
- ADDR_TX, 4, UART txdata register address
- ADDR_STATUS, 8, UART status register address
- RX_OK_BIT, 7, status bit meaning an rx byte is available
- TX_OK_BIT, 6, status bit meaning tx is ready
- IN_BYTES, 32, bytes per received 256-bit word
- OUT_BYTES, 31, bytes transmitted per result

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- avm_address  out  5  Avalon address
- avm_read  out  1  Avalon read request
- avm_readdata  in  32  Avalon read data; bits [7:0] used
- avm_write  out  1  Avalon write request
- avm_writedata  out  32  Avalon write data; bits [31:8] always 0
- avm_waitrequest  in  1  Avalon stall
- core_start  out  1  one-cycle start pulse to the RSA core
- core_a  out  256  cipher block
- core_d  out  256  exponent
- core_n  out  256  modulus
- core_result  in  256  a^d mod n
- core_finished  in  1  core done; result valid while this is high

Behaviour:
- Reset: i_rst, asynchronous, active-high; clock i_clk. All outputs are 0, avm_address = ADDR_STATUS, state = S_GET_N, byte counter = 0, and n/d/a registers are cleared.
- States: S_GET_N, S_GET_D, S_GET_A, S_START, S_WAIT_CALC, S_SEND.
- Byte transfer micro-sequence, identical in every get/send state:
  - POLL: avm_read=1 at ADDR_STATUS, held until avm_waitrequest=0. On that cycle sample the status bit (RX_OK_BIT for get states, TX_OK_BIT for send). Drop avm_read the next cycle.
  - If the bit is 0, re-poll. Back-to-back polls are allowed with one idle cycle between them.
  - If the bit is 1, issue the data access:
    - get states: avm_read at ADDR_RX.
    - S_SEND: avm_write at ADDR_TX with writedata = current byte.
  - Hold read/write until waitrequest=0, then deassert the next cycle.
  - Exactly one completed access per byte. No read or write is ever issued while waitrequest is high on the same request without holding it.
- Get states: shift the target register left by 8 and insert readdata[7:0] (MSB first). Increment the byte counter. At IN_BYTES, clear the counter and advance: N -> D -> A.
- S_START: core_start=1 for exactly one cycle, then S_WAIT_CALC. core_a/core_d/core_n stay stable from S_START until core_finished.
- S_WAIT_CALC: on the first cycle with core_finished=1, latch core_result into the output shift register and go to S_SEND. core_finished in any other state is ignored.
- S_SEND: send bytes result[247:240] first down to [7:0] (31 bytes). Bits [255:248] are never sent. After byte 31, clear the counter and go to S_GET_A. The key (n, d) is retained for later blocks.
- Counter is 5 bits and never wraps mid-word; it is cleared at each word boundary.
- Reset mid-operation (including mid Avalon access): read/write drop asynchronously and the FSM returns to S_GET_N. The key must be reloaded.

Decomposition:
- Shared package rsa_pkg: state enum type, UART address constants, status-bit indices, byte-count constants.
- One natural sub-module: uart_byte_port. It implements the poll-then-access Avalon micro-sequence, with a req/dir/byte_in interface returning done/byte_out. The top FSM keeps only the word and state logic.

Test Plan:
- Textbook key, no stalls: n=3233, d=2753, cipher=2790 (each zero-padded to 32 bytes); core model returns 65 -> 31 writes: 30×0x00 then 0x41. core_start pulses exactly once.
- waitrequest held 3 cycles on every access -> avm_read/avm_write held for 4 cycles each, one access per byte, byte values unchanged.
- RX status bit 0 for 10 polls before each byte -> exactly 10 extra status reads, zero ADDR_RX reads during that time.
- Two cipher blocks after one key -> second block starts at S_GET_A with the same n/d. The second core_start fires only after the 31st write of block 1.
- Spurious core_finished=1 pulse during S_GET_A -> ignored; no TX write, and the state is unchanged.
- Assert i_rst during the 10th byte of S_SEND -> avm_write=0 immediately. After release, the first data access is an ADDR_RX read that loads n.
